// File: rtl/gr_heep_obi_slave_mem.sv
// OBI responder backed by a word-addressed SRAM, with a fixed response latency,
// an outstanding-transaction limit and injectable grant backpressure.
package gr_heep_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module gr_heep_obi_slave_mem
    import gr_heep_obi_pkg::*;
#(
    parameter int unsigned NUM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = LATENCY,
    localparam int unsigned OW             = $clog2(LATENCY + 1),
    localparam int unsigned AW             = $clog2(NUM_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  obi_req_t        slave_req_i,
    output obi_resp_t       slave_resp_o,
    input  logic            stall_i,
    output logic [OW-1:0]   outstanding_o,
    output logic [15:0]     oor_count_o
);

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_MEM,
        SEL_OOR
    } rsel_e;

    logic [31:0]    r_mem [NUM_WORDS];
    logic [31:0]    r_rd_word;
    rsel_e          r_sel;
    logic [LATENCY-1:0] r_valid;
    logic [OW-1:0]  r_outstanding;
    logic [15:0]    r_oor_count;

    logic           w_gnt;
    logic           w_accept;
    logic           w_retire;
    logic           w_in_range;
    logic [32:0]    w_addr_ext;
    logic [32:0]    w_lo;
    logic [32:0]    w_hi;
    logic [AW-1:0]  w_index;
    logic [31:0]    w_stage_data [LATENCY];

    // 33-bit bounds so a window ending at 2^32 does not wrap
    assign w_addr_ext = {1'b0, slave_req_i.addr};
    assign w_lo       = {1'b0, BASE_ADDR};
    assign w_hi       = w_lo + (33'(NUM_WORDS) << 2);
    assign w_in_range = (w_addr_ext >= w_lo) && (w_addr_ext < w_hi);
    assign w_index    = AW'((slave_req_i.addr - BASE_ADDR) >> 2);

    assign w_retire = r_valid[LATENCY-1];
    assign w_gnt    = slave_req_i.req & ~stall_i &
                      ((r_outstanding < OW'(MAX_OUTSTANDING)) | w_retire);
    assign w_accept = slave_req_i.req & w_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
            r_oor_count   <= '0;
        end else begin
            if (w_accept && !w_retire) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_accept && w_retire) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_accept && !w_in_range && (r_oor_count != 16'hFFFF)) begin
                r_oor_count <= r_oor_count + 16'd1;
            end
        end
    end

    // Array is never reset so it maps onto block RAM; the read port is registered
    always_ff @(posedge clk_i) begin
        if (w_accept && slave_req_i.we && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (slave_req_i.be[i]) begin
                    r_mem[w_index][8*i +: 8] <= slave_req_i.wdata[8*i +: 8];
                end
            end
        end
        if (w_accept && !slave_req_i.we) begin
            r_rd_word <= r_mem[w_index];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_sel   <= SEL_ZERO;
        end else begin
            r_valid[0] <= w_accept;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            if (w_accept) begin
                if (slave_req_i.we) begin
                    r_sel <= SEL_ZERO;
                end else if (w_in_range) begin
                    r_sel <= SEL_MEM;
                end else begin
                    r_sel <= SEL_OOR;
                end
            end
        end
    end

    always_comb begin
        w_stage_data[0] = '0;
        case (r_sel)
            SEL_MEM: w_stage_data[0] = r_rd_word;
            SEL_OOR: w_stage_data[0] = 32'hBADCAB1E;
            default: w_stage_data[0] = '0;
        endcase
    end

    // Each stage loads only behind a valid, so the last stage holds rdata between responses
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            logic [31:0] r_data;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_data <= '0;
                end else if (r_valid[gi-1]) begin
                    r_data <= w_stage_data[gi-1];
                end
            end
            assign w_stage_data[gi] = r_data;
        end
    endgenerate

    assign slave_resp_o = '{gnt: w_gnt, rvalid: r_valid[LATENCY-1], rdata: w_stage_data[LATENCY-1]};
    assign outstanding_o = r_outstanding;
    assign oor_count_o   = r_oor_count;

endmodule

// File: tb/tb_gr_heep_obi_slave_mem.sv
// Directed bench for gr_heep_obi_slave_mem: four instances with different
// latency / limit / address-window parameters, one task per scenario.
module tb_gr_heep_obi_slave_mem;
    import gr_heep_obi_pkg::*;

    int tests_run    = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    obi_req_t  req0, req1, req2, req3;
    obi_resp_t resp0, resp1, resp2, resp3;
    logic      stall0, stall1, stall2, stall3;
    logic [0:0] out0;
    logic [1:0] out1;
    logic [2:0] out2;
    logic [0:0] out3;
    logic [15:0] oor0, oor1, oor2, oor3;

    gr_heep_obi_slave_mem u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req0), .slave_resp_o(resp0),
        .stall_i(stall0), .outstanding_o(out0), .oor_count_o(oor0));

    gr_heep_obi_slave_mem #(.NUM_WORDS(64), .LATENCY(3), .MAX_OUTSTANDING(3)) u_lat3 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req1), .slave_resp_o(resp1),
        .stall_i(stall1), .outstanding_o(out1), .oor_count_o(oor1));

    gr_heep_obi_slave_mem #(.NUM_WORDS(64), .LATENCY(4), .MAX_OUTSTANDING(2)) u_lat4 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req2), .slave_resp_o(resp2),
        .stall_i(stall2), .outstanding_o(out2), .oor_count_o(oor2));

    gr_heep_obi_slave_mem #(.NUM_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(1)) u_oor (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req3), .slave_resp_o(resp3),
        .stall_i(stall3), .outstanding_o(out3), .oor_count_o(oor3));

    // One-request transaction on a LATENCY=1 instance (d=0: u_lat1, d=3: u_oor);
    // returns gnt in the request cycle and rvalid/rdata in the following cycle.
    task automatic xfer1(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic g, output logic v, output logic [31:0] rd);
        obi_req_t r;
        r = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
        @(negedge clk);
        if (d == 0) req0 = r; else req3 = r;
        #1;
        g = (d == 0) ? resp0.gnt : resp3.gnt;
        @(posedge clk);
        @(negedge clk);
        if (d == 0) req0 = '0; else req3 = '0;
        #1;
        v  = (d == 0) ? resp0.rvalid : resp3.rvalid;
        rd = (d == 0) ? resp0.rdata : resp3.rdata;
        $display("[TB] xfer dut%0d we=%0b addr=%h wdata=%h be=%h -> gnt=%0b rvalid=%0b rdata=%h",
                 d, we, addr, wdata, be, g, v, rd);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (resp0.rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 0", resp0.rvalid); end
        tests_run++; if (resp0.rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 00000000", resp0.rdata); end
        tests_run++; if (resp1.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 0", resp1.gnt); end
        tests_run++; if (out1 !== 2'd0) begin tests_failed++; $display("FAIL reset_outstanding: got %0d expected 0", out1); end
        tests_run++; if (oor3 !== 16'd0) begin tests_failed++; $display("FAIL reset_oor: got %0d expected 0", oor3); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic g, v;
        logic [31:0] rd;
        xfer1(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, g, v, rd);
        tests_run++; if (g !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt: got %b expected 1", g); end
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL wr_rvalid: got %b expected 1", v); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
        xfer1(0, 1'b0, 32'h100, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid: got %b expected 1", v); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_rdata: got %h expected deadbeef", rd); end
        @(negedge clk);
        #1;
        tests_run++; if (resp0.rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_single_pulse: got %b expected 0", resp0.rvalid); end
        tests_run++; if (resp0.rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rdata_hold: got %h expected deadbeef", resp0.rdata); end
    endtask

    task automatic test_byte_enable();
        logic g, v;
        logic [31:0] rd;
        xfer1(0, 1'b1, 32'h104, 32'h11223344, 4'hF, g, v, rd);
        xfer1(0, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0101, g, v, rd);
        xfer1(0, 1'b0, 32'h107, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL be_merge: got %h expected 11bb33dd", rd); end
        xfer1(0, 1'b1, 32'h104, 32'hFFFFFFFF, 4'h0, g, v, rd);
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL be0_rvalid: got %b expected 1", v); end
        xfer1(0, 1'b0, 32'h104, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL be0_noop: got %h expected 11bb33dd", rd); end
    endtask

    // 8 writes then 8 reads, one request per cycle, on the LATENCY=3 instance
    task automatic test_back_to_back();
        int n = 16;
        logic [31:0] exp_rd [16];
        for (int k = 0; k < 16; k++)
            exp_rd[k] = (k < 8) ? 32'h0 : 32'hC0DE0000 + 32'(k - 8) * 32'h0101;
        for (int c = 0; c < n + 5; c++) begin
            logic exp_v;
            int acc, ret, exp_out;
            @(negedge clk);
            if (c < n)
                req1 = '{req: 1'b1, we: (c < 8), be: 4'hF, addr: 32'h40 + 32'(4 * (c % 8)),
                         wdata: 32'hC0DE0000 + 32'(c % 8) * 32'h0101};
            else
                req1 = '0;
            #1;
            $display("[TB] b2b cycle %0d gnt=%0b rvalid=%0b rdata=%h outstanding=%0d",
                     c, resp1.gnt, resp1.rvalid, resp1.rdata, out1);
            if (c < n) begin
                tests_run++; if (resp1.gnt !== 1'b1) begin tests_failed++; $display("FAIL b2b_gnt c%0d: got %b expected 1", c, resp1.gnt); end
            end
            exp_v = (c >= 3) && (c < n + 3);
            tests_run++; if (resp1.rvalid !== exp_v) begin tests_failed++; $display("FAIL b2b_rvalid c%0d: got %b expected %b", c, resp1.rvalid, exp_v); end
            if (exp_v) begin
                tests_run++; if (resp1.rdata !== exp_rd[c-3]) begin tests_failed++; $display("FAIL b2b_rdata c%0d: got %h expected %h", c, resp1.rdata, exp_rd[c-3]); end
            end
            acc = (c < n) ? c : n;
            ret = (c - 3 < 0) ? 0 : ((c - 3 > n) ? n : c - 3);
            exp_out = acc - ret;
            tests_run++; if (out1 !== 2'(exp_out)) begin tests_failed++; $display("FAIL b2b_outstanding c%0d: got %0d expected %0d", c, out1, exp_out); end
        end
    endtask

    task automatic test_outstanding_limit();
        for (int c = 0; c < 16; c++) begin
            logic exp_g, exp_v;
            @(negedge clk);
            req2 = (c < 12) ? '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0, wdata: 32'h0} : '0;
            #1;
            $display("[TB] limit cycle %0d gnt=%0b rvalid=%0b outstanding=%0d", c, resp2.gnt, resp2.rvalid, out2);
            if (c < 12) begin
                exp_g = (c % 4) < 2;
                tests_run++; if (resp2.gnt !== exp_g) begin tests_failed++; $display("FAIL limit_gnt c%0d: got %b expected %b", c, resp2.gnt, exp_g); end
            end
            exp_v = (c >= 4) && (((c - 4) % 4) < 2);
            tests_run++; if (resp2.rvalid !== exp_v) begin tests_failed++; $display("FAIL limit_rvalid c%0d: got %b expected %b", c, resp2.rvalid, exp_v); end
            tests_run++; if (!(out2 <= 3'd2)) begin tests_failed++; $display("FAIL limit_max c%0d: got %0d expected <=2", c, out2); end
        end
        tests_run++; if (out2 !== 3'd0) begin tests_failed++; $display("FAIL limit_drain: got %0d expected 0", out2); end
    endtask

    task automatic test_out_of_range();
        logic g, v;
        logic [31:0] rd;
        xfer1(3, 1'b0, 32'h1040, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'hBADCAB1E) begin tests_failed++; $display("FAIL oor_read: got %h expected badcab1e", rd); end
        xfer1(3, 1'b1, 32'h103C, 32'h0BADF00D, 4'hF, g, v, rd);
        xfer1(3, 1'b1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, g, v, rd);
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL oor_write_rvalid: got %b expected 1", v); end
        tests_run++; if (oor3 !== 16'd2) begin tests_failed++; $display("FAIL oor_count: got %0d expected 2", oor3); end
        xfer1(3, 1'b0, 32'h103C, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'h0BADF00D) begin tests_failed++; $display("FAIL oor_top_word: got %h expected 0badf00d", rd); end
        xfer1(3, 1'b1, 32'h1000, 32'h600DCAFE, 4'hF, g, v, rd);
        xfer1(3, 1'b0, 32'h1000, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'h600DCAFE) begin tests_failed++; $display("FAIL oor_base_word: got %h expected 600dcafe", rd); end
        tests_run++; if (oor3 !== 16'd2) begin tests_failed++; $display("FAIL oor_count_stable: got %0d expected 2", oor3); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 11; c++) begin
            logic exp_g, exp_v;
            @(negedge clk);
            stall1 = (c >= 1) && (c <= 5);
            req1 = (c <= 6) ? '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0} : '0;
            #1;
            $display("[TB] stall cycle %0d stall=%0b gnt=%0b rvalid=%0b rdata=%h", c, stall1, resp1.gnt, resp1.rvalid, resp1.rdata);
            exp_g = (c <= 6) && !stall1;
            exp_v = (c == 3) || (c == 9);
            tests_run++; if (resp1.gnt !== exp_g) begin tests_failed++; $display("FAIL stall_gnt c%0d: got %b expected %b", c, resp1.gnt, exp_g); end
            tests_run++; if (resp1.rvalid !== exp_v) begin tests_failed++; $display("FAIL stall_rvalid c%0d: got %b expected %b", c, resp1.rvalid, exp_v); end
            if (exp_v) begin
                tests_run++; if (resp1.rdata !== 32'hC0DE0000) begin tests_failed++; $display("FAIL stall_rdata c%0d: got %h expected c0de0000", c, resp1.rdata); end
            end
        end
        stall1 = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic g, v;
        logic [31:0] rd;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req1 = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h44 + 32'(4 * c), wdata: 32'h0};
        end
        @(negedge clk);
        req1 = '0;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset asserted with responses in flight: rvalid=%0b outstanding=%0d", resp1.rvalid, out1);
        tests_run++; if (resp1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_rvalid: got %b expected 0", resp1.rvalid); end
        tests_run++; if (out1 !== 2'd0) begin tests_failed++; $display("FAIL midrst_outstanding: got %0d expected 0", out1); end
        tests_run++; if (oor3 !== 16'd0) begin tests_failed++; $display("FAIL midrst_oor: got %0d expected 0", oor3); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            tests_run++; if (resp1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL postrst_rvalid c%0d: got %b expected 0", c, resp1.rvalid); end
        end
        for (int c = 0; c < 5; c++) begin
            logic exp_v;
            @(negedge clk);
            req1 = (c == 0) ? '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h44, wdata: 32'h0} : '0;
            #1;
            $display("[TB] post-reset read cycle %0d rvalid=%0b rdata=%h", c, resp1.rvalid, resp1.rdata);
            exp_v = (c == 3);
            tests_run++; if (resp1.rvalid !== exp_v) begin tests_failed++; $display("FAIL postrst_read_rvalid c%0d: got %b expected %b", c, resp1.rvalid, exp_v); end
            if (exp_v) begin
                tests_run++; if (resp1.rdata !== 32'hC0DE0101) begin tests_failed++; $display("FAIL postrst_read_rdata: got %h expected c0de0101", resp1.rdata); end
            end
        end
        xfer1(0, 1'b0, 32'h100, 32'h0, 4'h0, g, v, rd);
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL postrst_mem_kept: got %h expected deadbeef", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        req0   = '0; req1 = '0; req2 = '0; req3 = '0;
        stall0 = 1'b0; stall1 = 1'b0; stall2 = 1'b0; stall3 = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_outstanding_limit();
        test_out_of_range();
        test_stall();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
